// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared accumulator types, saturation limits and saturating adder
package tpu_pkg;

  localparam int DATA_W = 32;
  localparam logic signed [DATA_W-1:0] ACC_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [DATA_W-1:0] ACC_MIN = 32'sh8000_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] value;
    logic                     sat;
  } sat_sum_t;

  // One guard bit is enough: the two top bits disagree exactly on overflow.
  function automatic sat_sum_t sat_add(input logic signed [DATA_W-1:0] a,
                                       input logic signed [DATA_W-1:0] b);
    logic [DATA_W:0] wide;
    sat_sum_t        res;
    wide    = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    res.sat = wide[DATA_W] != wide[DATA_W-1];
    if (!res.sat)
      res.value = wide[DATA_W-1:0];
    else if (wide[DATA_W])
      res.value = ACC_MIN;
    else
      res.value = ACC_MAX;
    return res;
  endfunction

endpackage

// File: rtl/accum_mem.sv
// rtl/accum_mem.sv - single-clock accumulator RAM, one sync read port and one write port
module accum_mem
  import tpu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // A read of the address being written returns the previous contents.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/accumulator_unit.sv
// rtl/accumulator_unit.sv - per-row saturating partial-sum accumulator feeding the elementwise stage
module accumulator_unit
  import tpu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_addr,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     sat_flag
);

  acc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic                     s1_valid_q, s1_first_q, s1_last_q, s1_fwd_q;
  logic [ADDR_W-1:0]        s1_addr_q;
  logic signed [DATA_W-1:0] s1_data_q, s1_fwd_data_q;

  logic                     out_valid_q, sat_q;
  logic [ADDR_W-1:0]        out_addr_q;
  logic signed [DATA_W-1:0] out_data_q;

  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_waddr;
  logic [DATA_W-1:0]        mem_wdata, mem_rdata;

  logic                     accept, commit, emit, sum_sat;
  logic signed [DATA_W-1:0] operand, sum;
  sat_sum_t                 add_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // The sweep owns the write port; otherwise S2 commits, unless a clear flushes it.
  always_comb begin
    in_ready  = (state_q == IDLE);
    mem_we    = 1'b0;
    mem_waddr = s1_addr_q;
    mem_wdata = sum;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (commit) begin
      mem_we = 1'b1;
    end
  end

  assign accept  = in_valid && in_ready && !clear;
  assign commit  = s1_valid_q && !clear;
  assign emit    = commit && s1_last_q;
  assign operand = s1_fwd_q ? s1_fwd_data_q : mem_rdata;
  assign add_res = sat_add(operand, s1_data_q);
  assign sum     = s1_first_q ? s1_data_q : add_res.value;
  assign sum_sat = !s1_first_q && add_res.sat;

  accum_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (in_addr),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_fwd_q      <= 1'b0;
      s1_addr_q     <= '0;
      s1_data_q     <= '0;
      s1_fwd_data_q <= '0;
      out_valid_q   <= 1'b0;
      out_addr_q    <= '0;
      out_data_q    <= '0;
      sat_q         <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q     <= in_addr;
        s1_data_q     <= in_data;
        s1_first_q    <= in_first;
        s1_last_q     <= in_last;
        // The RAM read misses the write happening at this same edge.
        s1_fwd_q      <= s1_valid_q && (in_addr == s1_addr_q);
        s1_fwd_data_q <= sum;
      end
      out_valid_q <= emit;
      out_data_q  <= emit ? sum : '0;
      if (emit) out_addr_q <= s1_addr_q;
      if (clear)
        sat_q <= 1'b0;
      else if (commit && sum_sat)
        sat_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_accumulator_unit.sv
// tb/tb_accumulator_unit.sv - self-checking bench for accumulator_unit
module tb_accumulator_unit;

  logic               clk, reset, clear, in_valid, in_ready, in_first, in_last;
  logic               out_valid, sat_flag;
  logic [3:0]         in_addr, out_addr;
  logic signed [31:0] in_data, out_data;

  accumulator_unit #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .sat_flag  (sat_flag)
  );

  typedef struct {
    logic [3:0] addr;
    int         data;
    logic       first;
    logic       last;
    logic       exp_v;
    int         exp_d;
  } vec_t;

  typedef struct {
    logic [3:0] addr;
    int         data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_valid: got addr %0d data %0d expected no pulse", out_addr, out_data);
        end else begin
          e = sb.pop_front();
          chk("out_addr", out_addr, e.addr);
          chk("out_data", out_data, e.data);
          chk("out_latency", cyc, e.cyc);
        end
      end else begin
        chk("out_data_idle", out_data, 0);
      end
    end
  end

  task automatic send(input logic [3:0] a, input int d, input logic f, input logic l,
                      input logic ev, input int ed);
    int   n;
    exp_t e;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_first = f;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    if (ev) begin
      e.addr = a;
      e.data = ed;
      e.cyc  = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drain(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) send(4'(i), 0, 1'b0, 1'b1, 1'b1, 0);
    drain(4);
  endtask

  initial begin
    int n;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_addr = '0; in_data = '0; in_first = 1'b0; in_last = 1'b0;

    vecs.push_back('{4'd3, 10, 1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{4'd3, -4, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{4'd3, 7, 1'b0, 1'b1, 1'b1, 13});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{4'd5, 1, (i == 0), (i == 7), (i == 7), 8});
    vecs.push_back('{4'd5, 100, 1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{4'd6, -50, 1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{4'd5, 1, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{4'd6, -2, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{4'd5, 3, 1'b0, 1'b1, 1'b1, 104});
    vecs.push_back('{4'd6, -4, 1'b0, 1'b1, 1'b1, -56});
    vecs.push_back('{4'd9, 32'h7FFF_FFF0, 1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{4'd9, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF});
    vecs.push_back('{4'd1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{4'd1, -1, 1'b0, 1'b1, 1'b1, 32'h8000_0000});

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    wait_ready(n);
    chk("reset_ready_low_cycles", n, 16);
    read_all_zero();
    chk("sat_flag_clean", sat_flag, 0);

    foreach (vecs[i])
      send(vecs[i].addr, vecs[i].data, vecs[i].first, vecs[i].last, vecs[i].exp_v, vecs[i].exp_d);
    drain(4);
    chk("sat_flag_set", sat_flag, 1);
    chk("sb_empty_table", sb.size(), 0);

    // Clear the cycle after an accepted last input, with a colliding input.
    send(4'd2, 99, 1'b1, 1'b1, 1'b0, 0);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_addr = 4'd2; in_data = 5; in_first = 1'b0; in_last = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_sat_flag", sat_flag, 0);
    wait_ready(n);
    chk("clear_ready_low_cycles", n, 16);
    read_all_zero();

    // Async reset landing between S1 and S2.
    send(4'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
    send(4'd0, 1, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF);
    drain(4);
    chk("sat_flag_pre_reset", sat_flag, 1);
    send(4'd7, 123, 1'b1, 1'b1, 1'b0, 0);
    #2 reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_addr", out_addr, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_sat_flag", sat_flag, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    chk("mid_rst_ready_low_cycles", n, 16);
    send(4'd7, 0, 1'b0, 1'b1, 1'b1, 0);
    send(4'd0, 0, 1'b0, 1'b1, 1'b1, 0);
    drain(4);
    chk("sb_empty_final", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
